dpram_stream_reader: RTL and testbench
======================================

// Module: dpram_stream_reader
// PURPOSE
//  Read-side controller placed directly downstream of the dpram block, in the
//  dpram read-clock domain.
//  On a start pulse it issues a burst of sequential reads (re/raddr) to the RAM.
//  It realigns the RAM's fixed read latency (1 or 2 cycles) and presents the words
//  as a valid/ready stream through an internal 4-entry skid FIFO.
//  Full throughput under backpressure; no read data is ever lost.
// PARAMETERS
//  DATA_WIDTH   8  RAM word width; must match the dpram instance.
//  ADDR_WIDTH   9  RAM address width; must match the dpram instance.
//  RD_LATENCY   2  Cycles from ram_re to valid ram_rdata: 2 = OUTPUT_REG "TRUE", 1 = "FALSE".
// PORTS
//  clk         in   1           Read clock; drives dpram rclk.
//  rst_n       in   1           Asynchronous reset, active low.
//  start       in   1           Burst request; sampled only in IDLE.
//  start_addr  in   ADDR_WIDTH  First read address.
//  length      in   ADDR_WIDTH+1  Word count, 0..2**ADDR_WIDTH.
//  busy        out  1           Burst in progress.
//  done        out  1           One-cycle pulse at burst completion.
//  ram_re      out  1           To dpram re (registered).
//  ram_raddr   out  ADDR_WIDTH  To dpram raddr (registered).
//  ram_rdata   in   DATA_WIDTH  From dpram rdata.
//  m_data      out  DATA_WIDTH  Stream data (FIFO head).
//  m_valid     out  1           Stream valid.
//  m_ready     in   1           Stream ready from consumer.
// BEHAVIOUR
//  Reset values: busy=0, done=0, ram_re=0, ram_raddr=0, m_valid=0, m_data=0.
//  Reset clears the FSM, FIFO, in-flight pipe and counters. Reset mid-burst
//    aborts the burst; no done pulse; RAM data still in flight is discarded.
//  FSM states:
//   IDLE  -> READ   on start with length!=0; latch start_addr and length.
//   IDLE  -> IDLE   on start with length==0; done pulses the next cycle, busy stays 0.
//   READ  -> DRAIN  on the cycle the last read is issued.
//   DRAIN -> IDLE   when FIFO empty, in-flight=0 and last word accepted;
//                   done=1 for that one cycle.
//  start is ignored outside IDLE.
//  busy=1 in READ and DRAIN. done is asserted in the cycle busy falls.
//  Issue rule:
//   - A read is issued on cycle n when (fifo_count + inflight) < 4, counted after
//     this cycle's pop and capture.
//   - Issuing sets ram_re=1 and ram_raddr=next address, both registered.
//  Addresses increment by 1 per issued read and wrap modulo 2**ADDR_WIDTH.
//  In-flight tracking: shift register of depth RD_LATENCY carrying re.
//    Its output strobes capture of ram_rdata into the FIFO.
//  Capture ignores m_ready; the credit rule guarantees the FIFO never overflows.
//  Latency: first read issued (ram_re=1) at cycle 1 after start sampled at cycle 0.
//    m_valid first rises at cycle RD_LATENCY+2.
//  Throughput: with m_ready held at 1, one word per cycle sustained.
//  Transfer occurs when m_valid & m_ready.
//  m_data/m_valid hold stable while m_valid & !m_ready.
//  A FIFO push and pop in the same cycle leave the count unchanged.
//  length=2**ADDR_WIDTH reads every location once, starting at start_addr.
// TESTING
//  1 RD_LATENCY=2, RAM[i]=i, start_addr=0x010, length=8, m_ready=1
//    -> m_data 0x10..0x17, m_valid first at cycle 4; done one cycle; busy 7..0 transitions correct.
//  2 start_addr=0x1FE, length=4 (ADDR_WIDTH=9)
//    -> ram_raddr 0x1FE,0x1FF,0x000,0x001; m_data order matches.
//  3 length=16, m_ready toggled 1 cycle on / 3 off
//    -> all 16 words in order, no drop or duplicate; inflight+fifo_count never exceeds 4.
//  4 length=0 start -> no ram_re; done at cycle 1; busy stays 0.
//    start pulsed while busy -> ignored, burst unchanged.
//  5 rst_n asserted low mid-burst (after 3 words)
//    -> all outputs return to reset values immediately; no done.
//    A new start after release streams the correct data.
//  6 RD_LATENCY=1 with dpram OUTPUT_REG="FALSE", length=8, m_ready=1
//    -> m_valid first at cycle 3; data correct; 1 word/cycle.

Source files
------------

// File: rtl/dpram_stream_reader_if.sv
// Bundle of the burst-control, RAM read-port and output-stream signals of
// dpram_stream_reader. The reader takes the master view; the environment
// (burst requester, RAM and stream consumer) takes the slave view.
interface dpram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  start, start_addr, length, ram_rdata, m_ready,
        output busy, done, ram_re, ram_raddr, m_data, m_valid
    );

    modport slave (
        output start, start_addr, length, ram_rdata, m_ready,
        input  busy, done, ram_re, ram_raddr, m_data, m_valid
    );
endinterface

// File: rtl/dpram_stream_reader.sv
// Burst read controller for the dpram read port. Issues sequential reads,
// realigns the RAM read latency with a re shift register and streams the
// words out through a 4-entry FIFO. Reads are only issued while the words
// already owed (in flight plus buffered) stay within the FIFO depth, so the
// capture side never has to stall and no read data is dropped.
module dpram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remain_q;
    logic                  ram_re_q;
    logic [ADDR_WIDTH-1:0] ram_raddr_q;
    logic                  done_q, done_nx;
    logic [RD_LATENCY-1:0] re_pipe_p;
    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_count;
    logic                  issue, load, capture, pop;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [3:0]            occ;

    assign capture       = re_pipe_p[RD_LATENCY-1];
    assign bus.m_valid   = (fifo_count != 3'd0);
    assign pop           = bus.m_valid & bus.m_ready;
    assign bus.m_data    = (fifo_count != 3'd0) ? fifo_mem[rd_ptr] : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_raddr = ram_raddr_q;

    // Words owed after this edge (buffered + in flight), before any new issue
    always_comb begin
        occ = {1'b0, fifo_count} + {3'b0, ram_re_q};
        for (int i = 0; i < RD_LATENCY; i++) begin
            occ = occ + {3'b0, re_pipe_p[i]};
        end
        occ = occ - {3'b0, pop};
    end

    // Next-state, read issue and completion decode
    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        load       = 1'b0;
        issue_addr = addr_q;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        load       = 1'b1;
                        issue_addr = bus.start_addr;
                        state_nx   = (bus.length == (ADDR_WIDTH+1)'(1)) ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                if (occ < 4'd4) begin
                    issue = 1'b1;
                    if (remain_q == (ADDR_WIDTH+1)'(1)) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == 4'd0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control state, registered RAM read port and latency-alignment pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_raddr_q <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            re_pipe_p   <= '0;
        end else begin
            state        <= state_nx;
            done_q       <= done_nx;
            ram_re_q     <= issue;
            if (issue) ram_raddr_q <= issue_addr;
            re_pipe_p[0] <= ram_re_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                re_pipe_p[i] <= re_pipe_p[i-1];
            end
            if (load) begin
                addr_q   <= bus.start_addr + 1'b1;
                remain_q <= bus.length - 1'b1;
            end else if (issue) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage: capture RAM data when the aligned re strobe emerges
    always_ff @(posedge clk) begin
        if (capture) fifo_mem[wr_ptr] <= bus.ram_rdata;
    end
endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: two instances (read latency 2 and 1) run the
// same bursts side by side against behavioural RAM models. Expected words are
// mem[(start_addr + n) mod 512] for the n-th accepted transfer.
module tb_dpram_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] start_addr;
    logic [9:0] length;
    logic       m_ready;
    logic [7:0] mem [512];
    logic [7:0] ra1, ra2, rb1;
    int         asserts = 0;
    int         fails = 0;
    int         lat [2];

    dpram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) ifa ();
    dpram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) ifb ();

    dpram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .RD_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master));
    dpram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .RD_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master));

    always #5 clk = ~clk;

    assign ifa.start = start;      assign ifb.start = start;
    assign ifa.start_addr = start_addr; assign ifb.start_addr = start_addr;
    assign ifa.length = length;    assign ifb.length = length;
    assign ifa.m_ready = m_ready;  assign ifb.m_ready = m_ready;

    // RAM models: registered read, optional output register on instance a
    always @(posedge clk) begin
        if (ifa.ram_re) ra1 <= mem[ifa.ram_raddr];
        ra2 <= ra1;
        if (ifb.ram_re) rb1 <= mem[ifb.ram_raddr];
    end
    assign ifa.ram_rdata = ra2;
    assign ifb.ram_rdata = rb1;

    logic       mv [2], bsy [2], dn [2], re [2];
    logic [7:0] md [2];
    logic [8:0] ra [2];
    assign mv[0] = ifa.m_valid; assign mv[1] = ifb.m_valid;
    assign bsy[0] = ifa.busy;   assign bsy[1] = ifb.busy;
    assign dn[0] = ifa.done;    assign dn[1] = ifb.done;
    assign re[0] = ifa.ram_re;  assign re[1] = ifb.ram_re;
    assign md[0] = ifa.m_data;  assign md[1] = ifb.m_data;
    assign ra[0] = ifa.ram_raddr; assign ra[1] = ifb.ram_raddr;

    // mode 0: ready always; 1: one cycle on, three off; 2: random
    task automatic run_burst(input logic [8:0] addr, input logic [9:0] len,
                             input int mode, input int xs_cyc, input string tag);
        int issued [2], xfer [2], first_v [2], done_c [2];
        logic hold_v [2];
        logic [7:0] hold_d [2];
        logic [7:0] expv;
        logic exp_busy;
        int c, limit;
        bit fin;
        for (int k = 0; k < 2; k++) begin
            issued[k] = 0; xfer[k] = 0; first_v[k] = -1; done_c[k] = -1; hold_v[k] = 1'b0;
            hold_d[k] = '0;
        end
        limit = 4 * int'(len) + 40;
        start = 1'b1; start_addr = addr; length = len;
        c = 0; fin = 0;
        while (!fin) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0;
            if (c == xs_cyc) begin
                start = 1'b1; start_addr = 9'($urandom); length = 10'd5;
            end
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (c % 4 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            for (int k = 0; k < 2; k++) begin
                if (re[k] === 1'b1) begin
                    asserts++;
                    if (int'(ra[k]) != (int'(addr) + issued[k]) % 512)
                        begin fails++; $display("FAIL %s dut%0d raddr c%0d: got %h expected %h", tag, k, c, ra[k], 9'((int'(addr) + issued[k]) % 512)); end
                    issued[k]++;
                end
                asserts++;
                if (issued[k] - xfer[k] > 4)
                    begin fails++; $display("FAIL %s dut%0d occupancy c%0d: got %0d expected <=4", tag, k, c, issued[k] - xfer[k]); end
                if (hold_v[k]) begin
                    asserts++;
                    if (mv[k] !== 1'b1 || md[k] !== hold_d[k])
                        begin fails++; $display("FAIL %s dut%0d hold c%0d: got v=%b d=%h expected v=1 d=%h", tag, k, c, mv[k], md[k], hold_d[k]); end
                end
                if (mv[k] === 1'b1 && first_v[k] < 0) begin
                    first_v[k] = c;
                    if (mode == 0) begin
                        asserts++;
                        if (c != lat[k] + 2)
                            begin fails++; $display("FAIL %s dut%0d first_valid: got c%0d expected c%0d", tag, k, c, lat[k] + 2); end
                    end
                end
                if (done_c[k] < 0) begin
                    exp_busy = (len != 0) && (dn[k] !== 1'b1);
                    asserts++;
                    if (bsy[k] !== exp_busy)
                        begin fails++; $display("FAIL %s dut%0d busy c%0d: got %b expected %b", tag, k, c, bsy[k], exp_busy); end
                end
                if (dn[k] === 1'b1) begin
                    if (done_c[k] < 0) done_c[k] = c;
                    else begin asserts++; fails++; $display("FAIL %s dut%0d done_pulse c%0d: got 1 expected 0", tag, k, c); end
                end
                if (mv[k] === 1'b1 && m_ready) begin
                    asserts++;
                    if (xfer[k] >= int'(len)) begin
                        fails++; $display("FAIL %s dut%0d extra_word c%0d: got %h expected none", tag, k, c, md[k]);
                    end else begin
                        expv = mem[(int'(addr) + xfer[k]) % 512];
                        if (md[k] !== expv)
                            begin fails++; $display("FAIL %s dut%0d data%0d: got %h expected %h", tag, k, xfer[k], md[k], expv); end
                    end
                    xfer[k]++;
                end
                hold_v[k] = (mv[k] === 1'b1) && !m_ready;
                hold_d[k] = md[k];
            end
            if (done_c[0] >= 0 && done_c[1] >= 0 && c > done_c[0] && c > done_c[1]) fin = 1;
            if (c > limit) begin
                asserts++; fails++; fin = 1;
                $display("FAIL %s timeout: got done a=%0d b=%0d expected completion by c%0d", tag, done_c[0], done_c[1], limit);
            end
        end
        for (int k = 0; k < 2; k++) begin
            asserts++;
            if (xfer[k] != int'(len) || issued[k] != int'(len))
                begin fails++; $display("FAIL %s dut%0d counts: got xfer=%0d issued=%0d expected %0d", tag, k, xfer[k], issued[k], len); end
            if (len == 0) begin
                asserts++;
                if (done_c[k] != 1)
                    begin fails++; $display("FAIL %s dut%0d done_zero: got c%0d expected c1", tag, k, done_c[k]); end
            end else if (mode == 0) begin
                asserts++;
                if (done_c[k] != int'(len) + lat[k] + 2)
                    begin fails++; $display("FAIL %s dut%0d done_cycle: got c%0d expected c%0d", tag, k, done_c[k], int'(len) + lat[k] + 2); end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            asserts++;
            if ({bsy[k], dn[k], re[k], mv[k]} !== 4'b0 || ra[k] !== 9'd0 || md[k] !== 8'd0)
                begin fails++; $display("FAIL reset dut%0d: got b%b d%b re%b v%b a%h m%h expected all zero", k, bsy[k], dn[k], re[k], mv[k], ra[k], md[k]); end
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 512; i++) mem[i] = i[7:0];
        run_burst(9'h010, 10'd8, 0, -1, "basic");
    endtask

    task automatic test_wrap();
        run_burst(9'h1FE, 10'd4, 0, -1, "wrap");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_burst(9'($urandom), 10'd16, 1, -1, "backpressure");
    endtask

    task automatic test_zero_length();
        run_burst(9'($urandom), 10'd0, 0, -1, "zero_len");
    endtask

    task automatic test_start_while_busy();
        run_burst(9'($urandom), 10'd10, 0, 3, "start_busy");
    endtask

    task automatic test_reset_mid_burst();
        start = 1'b1; start_addr = 9'($urandom); length = 10'd16; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            asserts++;
            if ({bsy[k], dn[k], re[k], mv[k]} !== 4'b0 || ra[k] !== 9'd0 || md[k] !== 8'd0)
                begin fails++; $display("FAIL mid_reset dut%0d: got b%b d%b re%b v%b a%h m%h expected all zero", k, bsy[k], dn[k], re[k], mv[k], ra[k], md[k]); end
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                asserts++;
                if (dn[k] !== 1'b0 || mv[k] !== 1'b0)
                    begin fails++; $display("FAIL post_reset dut%0d: got done=%b valid=%b expected 0", k, dn[k], mv[k]); end
            end
        end
        run_burst(9'($urandom), 10'd12, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
            run_burst(9'($urandom), 10'($urandom_range(1, 40)), 2, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_burst(9'h100, 10'd3, 0, -1, "b2b_first");
        run_burst(9'h103, 10'd1, 0, -1, "b2b_single");
        run_burst(9'h104, 10'd5, 0, -1, "b2b_second");
    endtask

    task automatic test_full_length();
        run_burst(9'h0A5, 10'd512, 0, -1, "full_length");
    endtask

    initial begin
        lat = '{2, 1};
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_burst();
        test_random();
        test_back_to_back();
        test_full_length();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
